izh_neuron_array: RTL and testbench

Time-multiplexed array of N Izhikevich neurons sharing one signed fixed-point datapath. Per-neuron v/u state lives in internal register files. a, b, c, d and threshold are runtime-programmable and shared by all neurons. One `tick` advances every neuron by one Euler step. The result is a spike vector with a done pulse, for downstream spike routing and monitoring.

---
 rtl/izh_neuron_array.sv | 176 +++++++++++++++++
 tb/tb_izh_neuron_array.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/izh_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: one shared fixed-point datapath
// steps every neuron once per tick, one neuron per clock.
module izh_neuron_array #(
   parameter int N        = 4,
   parameter int WIDTH    = 16,
   parameter int FRAC     = 7,
   parameter int DT_SHIFT = 0,
   parameter int K1       = 5,
   parameter int V_INIT   = -8320,
   parameter int A_INIT   = 3,
   parameter int B_INIT   = 26,
   parameter int C_INIT   = -8320,
   parameter int D_INIT   = 1024,
   parameter int TH_INIT  = 3840,
   localparam int SW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      tick,
   input  logic [N*WIDTH-1:0]        current,
   input  logic                      cfg_we,
   input  logic [2:0]                cfg_addr,
   input  logic signed [WIDTH-1:0]   cfg_data,
   output logic                      busy,
   output logic                      step_done,
   output logic [N-1:0]              spikes,
   output logic                      overrun,
   input  logic [SW-1:0]             mon_sel,
   output logic signed [WIDTH-1:0]   mon_v,
   output logic signed [WIDTH-1:0]   mon_u
);

   localparam int IW = 2*WIDTH + 8;
   localparam logic signed [IW-1:0] K1_X   = IW'(K1);
   localparam logic signed [IW-1:0] FIVE_X = IW'(5);
   localparam logic signed [IW-1:0] C140_X = IW'(140) <<< FRAC;
   localparam logic signed [IW-1:0] MAX_X  = {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [IW-1:0] MIN_X  = {{(IW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                   state_reg;
   logic [SW-1:0]            idx_reg;
   logic                     busy_reg;
   logic                     step_done_reg;
   logic [N-1:0]             spikes_reg;
   logic                     overrun_reg;
   logic [N-1:0]             shadow_reg;
   logic [N-1:0]             shadow_next;
   logic [N*WIDTH-1:0]       cur_reg;

   logic signed [WIDTH-1:0]  v_mem [N];
   logic signed [WIDTH-1:0]  u_mem [N];
   logic signed [WIDTH-1:0]  cur_arr [N];

   logic signed [WIDTH-1:0]  a_reg, b_reg, c_reg, d_reg, th_reg;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] x);
      if (x > MAX_X)
         return MAX_X[WIDTH-1:0];
      else if (x < MIN_X)
         return MIN_X[WIDTH-1:0];
      else
         return x[WIDTH-1:0];
   endfunction

   // Unpack the latched current bus so the datapath can index it by neuron.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cur
         assign cur_arr[gi] = cur_reg[gi*WIDTH +: WIDTH];
      end
   endgenerate

   logic signed [IW-1:0]    v_x, u_x, i_x, a_x, b_x, d_x;
   logic signed [IW-1:0]    dv, bv, du;
   logic signed [WIDTH-1:0] v_new, u_new, u_spk, v_wr, u_wr;
   logic                    spike;

   always_comb begin
      v_x   = IW'(v_mem[idx_reg]);
      u_x   = IW'(u_mem[idx_reg]);
      i_x   = IW'(cur_arr[idx_reg]);
      a_x   = IW'(a_reg);
      b_x   = IW'(b_reg);
      d_x   = IW'(d_reg);
      dv    = ((K1_X * v_x * v_x) >>> (2*FRAC)) + (FIVE_X * v_x) + C140_X - u_x + i_x;
      v_new = sat(v_x + (dv >>> DT_SHIFT));
      bv    = (b_x * v_x) >>> FRAC;
      du    = (a_x * (bv - u_x)) >>> FRAC;
      u_new = sat(u_x + (du >>> DT_SHIFT));
      u_spk = sat(IW'(u_new) + d_x);
      spike = (v_new >= th_reg);
      v_wr  = spike ? c_reg : v_new;
      u_wr  = spike ? u_spk : u_new;
   end

   // Bits below idx were written earlier in this step; merge the current one.
   always_comb begin
      shadow_next          = shadow_reg;
      shadow_next[idx_reg] = spike;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= S_IDLE;
         idx_reg       <= '0;
         busy_reg      <= 1'b0;
         step_done_reg <= 1'b0;
         spikes_reg    <= '0;
         overrun_reg   <= 1'b0;
         shadow_reg    <= '0;
         cur_reg       <= '0;
         a_reg         <= WIDTH'(A_INIT);
         b_reg         <= WIDTH'(B_INIT);
         c_reg         <= WIDTH'(C_INIT);
         d_reg         <= WIDTH'(D_INIT);
         th_reg        <= WIDTH'(TH_INIT);
         for (int i = 0; i < N; i++) begin
            v_mem[i] <= WIDTH'(V_INIT);
            u_mem[i] <= '0;
         end
      end else begin
         step_done_reg <= 1'b0;
         if (cfg_we && !busy_reg) begin
            case (cfg_addr)
               3'd0:    a_reg  <= cfg_data;
               3'd1:    b_reg  <= cfg_data;
               3'd2:    c_reg  <= cfg_data;
               3'd3:    d_reg  <= cfg_data;
               3'd4:    th_reg <= cfg_data;
               default: ;
            endcase
         end
         case (state_reg)
            S_IDLE: begin
               if (tick) begin
                  cur_reg   <= current;
                  idx_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= S_RUN;
               end
            end
            S_RUN: begin
               v_mem[idx_reg] <= v_wr;
               u_mem[idx_reg] <= u_wr;
               shadow_reg     <= shadow_next;
               if (tick)
                  overrun_reg <= 1'b1;
               if (idx_reg == SW'(N-1)) begin
                  spikes_reg    <= shadow_next;
                  step_done_reg <= 1'b1;
                  state_reg     <= S_DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            S_DONE: begin
               if (tick)
                  overrun_reg <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_reg;
   assign step_done = step_done_reg;
   assign spikes    = spikes_reg;
   assign overrun   = overrun_reg;
   assign mon_v     = v_mem[mon_sel];
   assign mon_u     = u_mem[mon_sel];

endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array with hand-computed Q9.7 expectations.
module tb_izh_neuron_array;

   localparam int N = 4;
   localparam int W = 16;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  tick = 1'b0;
   logic [N*W-1:0]        current = '0;
   logic                  cfg_we = 1'b0;
   logic [2:0]            cfg_addr = '0;
   logic signed [W-1:0]   cfg_data = '0;
   logic                  busy;
   logic                  step_done;
   logic [N-1:0]          spikes;
   logic                  overrun;
   logic [1:0]            mon_sel = '0;
   logic signed [W-1:0]   mon_v;
   logic signed [W-1:0]   mon_u;

   int errors = 0;
   int checks = 0;
   int done_cnt;
   int pulses;

   izh_neuron_array dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .current   (current),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .busy      (busy),
      .step_done (step_done),
      .spikes    (spikes),
      .overrun   (overrun),
      .mon_sel   (mon_sel),
      .mon_v     (mon_v),
      .mon_u     (mon_u)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic cfg_write(input logic [2:0] addr, input logic signed [W-1:0] data);
      cfg_we   = 1'b1;
      cfg_addr = addr;
      cfg_data = data;
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
   endtask

   // Pulses tick, waits (bounded) for step_done, then steps back into IDLE.
   task automatic run_step(input string tag);
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      done_cnt = 0;
      while (!step_done && done_cnt < 20) begin
         @(posedge clk);
         #1;
         done_cnt++;
      end
      chk({tag, "_done_seen"}, 32'(step_done), 1);
      $display("step %s: spikes=%b cycles=%0d", tag, spikes, done_cnt + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_nrn(input int n, input int ev, input int eu);
      mon_sel = 2'(n);
      #1;
      chk($sformatf("mon_v[%0d]", n), 32'(mon_v), ev);
      chk($sformatf("mon_u[%0d]", n), 32'(mon_u), eu);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_spikes", 32'(spikes), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_step_done", 32'(step_done), 0);
      for (int n = 0; n < N; n++) chk_nrn(n, -8320, 0);

      // Single step, I=0: latency and quiescent update
      current = '0;
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      chk("run_busy", 32'(busy), 1);
      done_cnt = 0;
      while (!step_done && done_cnt < 20) begin
         @(posedge clk);
         #1;
         done_cnt++;
      end
      chk("done_latency", done_cnt + 1, N + 1);
      chk("done_busy", 32'(busy), 1);
      chk("spikes_i0", 32'(spikes), 0);
      @(posedge clk);
      #1;
      chk("done_pulse_one_cycle", 32'(step_done), 0);
      chk("idle_busy", 32'(busy), 0);
      $display("step single: cycles=%0d spikes=%b", done_cnt + 1, spikes);
      for (int n = 0; n < N; n++) chk_nrn(n, -10875, -40);

      // Spike on neuron 0 only
      do_reset();
      current = '0;
      current[0 +: W] = 16'sd32767;
      run_step("spike");
      chk("spikes_n0", 32'(spikes), 32'b0001);
      chk_nrn(0, -8320, 984);
      for (int n = 1; n < N; n++) chk_nrn(n, -10875, -40);

      // Negative saturation of v
      do_reset();
      for (int n = 0; n < N; n++) current[n*W +: W] = 16'h8000;
      run_step("sat_neg");
      chk("spikes_sat", 32'(spikes), 0);
      for (int n = 0; n < N; n++) chk_nrn(n, -32768, -40);

      // Threshold equality boundary: v_new == threshold spikes
      do_reset();
      current = '0;
      cfg_write(3'd4, -16'sd10875);
      run_step("th_eq");
      chk("spikes_th_eq", 32'(spikes), 32'b1111);
      chk_nrn(2, -8320, 984);
      do_reset();
      cfg_write(3'd4, -16'sd10874);
      run_step("th_above");
      chk("spikes_th_above", 32'(spikes), 0);
      chk_nrn(2, -10875, -40);

      // Config write of c, plus a write while busy that must be dropped
      do_reset();
      current = '0;
      current[0 +: W] = 16'sd32767;
      cfg_write(3'd2, -16'sd6400);
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      cfg_write(3'd2, -16'sd100);
      done_cnt = 0;
      while (!step_done && done_cnt < 20) begin
         @(posedge clk);
         #1;
         done_cnt++;
      end
      chk("cfg_done_seen", 32'(step_done), 1);
      @(posedge clk);
      #1;
      $display("step cfg_c: spikes=%b", spikes);
      chk_nrn(0, -6400, 984);
      run_step("cfg_c_again");
      chk("spikes_cfg2", 32'(spikes[0]), 1);
      chk_nrn(0, -6400, 1954);
      chk("overrun_clear", 32'(overrun), 0);

      // Write and tick in the same IDLE cycle: the step sees the new c
      cfg_we   = 1'b1;
      cfg_addr = 3'd2;
      cfg_data = -16'sd5000;
      run_step("cfg_with_tick");
      cfg_we   = 1'b0;
      chk_nrn(0, -5000, 2901);

      // Overrun: second tick two cycles after the first
      do_reset();
      current = '0;
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      @(posedge clk);
      #1;
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      pulses = 0;
      for (int c = 0; c < 15; c++) begin
         if (step_done) pulses++;
         @(posedge clk);
         #1;
      end
      $display("step overrun: pulses=%0d overrun=%b", pulses, overrun);
      chk("overrun_pulses", pulses, 1);
      chk("overrun_set", 32'(overrun), 1);
      chk_nrn(1, -10875, -40);
      run_step("overrun_sticky");
      chk("overrun_sticky", 32'(overrun), 1);

      // Tick in the step_done cycle is ignored
      do_reset();
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      done_cnt = 0;
      while (!step_done && done_cnt < 20) begin
         @(posedge clk);
         #1;
         done_cnt++;
      end
      chk("b2b_done_seen", 32'(step_done), 1);
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      $display("step b2b: busy=%b overrun=%b", busy, overrun);
      chk("b2b_ignored", 32'(busy), 0);
      chk("b2b_overrun", 32'(overrun), 1);

      // Reset while neuron 2 is being processed
      do_reset();
      current = '0;
      current[0 +: W] = 16'sd32767;
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_spikes", 32'(spikes), 0);
      chk_nrn(0, -8320, 0);
      chk_nrn(1, -8320, 0);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (step_done) pulses++;
         @(posedge clk);
         #1;
      end
      $display("step midrst: pulses=%0d", pulses);
      chk("midrst_no_done", pulses, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
